// File: rtl/sc_matrix_pkg.sv
// rtl/sc_matrix_pkg.sv - shared state encoding and timing constants for the LED-matrix scanner
package sc_matrix_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        DISPLAY = 2'd2,
        BLANK   = 2'd3
    } scanState_t;

    localparam int ROW_CYCLES_1MS    = 50000;
    localparam int BLANK_CYCLES_10US = 500;

    // Bits needed to hold 0..value-1, never narrower than one bit.
    function automatic int clogMin1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/sc_matrix_scan_timer.sv
// rtl/sc_matrix_scan_timer.sv - loadable down-counter with zero flag, shared by the lit and blank intervals
module sc_matrix_scan_timer #(
    parameter int WIDTH = 16
) (
    input  logic             SC_RegGENERAL_CLOCK_50,
    input  logic             SC_RegGENERAL_RESET_InHigh,
    input  logic             timerLoad,
    input  logic [WIDTH-1:0] timerLoadValue,
    output logic             timerZero
);

    logic [WIDTH-1:0] timerCount;

    // Saturates at zero so an idle timer simply parks there.
    always_ff @(posedge SC_RegGENERAL_CLOCK_50 or posedge SC_RegGENERAL_RESET_InHigh) begin
        if (SC_RegGENERAL_RESET_InHigh) begin
            timerCount <= '0;
        end else if (timerLoad) begin
            timerCount <= timerLoadValue;
        end else if (timerCount != '0) begin
            timerCount <= timerCount - 1'b1;
        end
    end

    assign timerZero = (timerCount == '0);

endmodule

// File: rtl/sc_matrix_scan.sv
// rtl/sc_matrix_scan.sv - time-sliced row scanner driving an LED matrix from the general-register image
module sc_matrix_scan
    import sc_matrix_pkg::*;
#(
    parameter int DATAWIDTH    = 8,
    parameter int ROWS         = 8,
    parameter int ROW_CYCLES   = ROW_CYCLES_1MS,
    parameter int BLANK_CYCLES = BLANK_CYCLES_10US
) (
    input  logic                      SC_RegGENERAL_CLOCK_50,
    input  logic                      SC_RegGENERAL_RESET_InHigh,
    input  logic                      scan_enable_InHigh,
    input  logic [ROWS*DATAWIDTH-1:0] scan_data_InBUS,
    output logic [ROWS-1:0]           scan_row_OutBUS,
    output logic [DATAWIDTH-1:0]      scan_col_OutBUS,
    output logic                      scan_frame_done_OutHigh
);

    localparam int CNT_W = clogMin1((ROW_CYCLES > BLANK_CYCLES) ? ROW_CYCLES : BLANK_CYCLES);
    localparam int ROW_W = clogMin1(ROWS);
    localparam logic [CNT_W-1:0] ROW_RELOAD   = CNT_W'(ROW_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_RELOAD = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [ROW_W-1:0] LAST_ROW     = ROW_W'(ROWS - 1);

    scanState_t           state, stateNext;
    logic [ROW_W-1:0]     rowIdx, rowIdxNext;
    logic [DATAWIDTH-1:0] shadow, shadowNext;
    logic [DATAWIDTH-1:0] rowSlice;
    logic [ROWS-1:0]      rowOneHot;
    logic [ROWS-1:0]      rowOutNext;
    logic [DATAWIDTH-1:0] colOutNext;
    logic                 frameDoneNext;
    logic                 timerLoad;
    logic [CNT_W-1:0]     timerLoadValue;
    logic                 timerZero;

    assign rowSlice  = scan_data_InBUS[rowIdx*DATAWIDTH +: DATAWIDTH];
    assign rowOneHot = ROWS'(1) << rowIdx;

    sc_matrix_scan_timer #(
        .WIDTH (CNT_W)
    ) u_timer (
        .SC_RegGENERAL_CLOCK_50     (SC_RegGENERAL_CLOCK_50),
        .SC_RegGENERAL_RESET_InHigh (SC_RegGENERAL_RESET_InHigh),
        .timerLoad                  (timerLoad),
        .timerLoadValue             (timerLoadValue),
        .timerZero                  (timerZero)
    );

    always_ff @(posedge SC_RegGENERAL_CLOCK_50 or posedge SC_RegGENERAL_RESET_InHigh) begin
        if (SC_RegGENERAL_RESET_InHigh) begin
            state                   <= IDLE;
            rowIdx                  <= '0;
            shadow                  <= '0;
            scan_row_OutBUS         <= '0;
            scan_col_OutBUS         <= '0;
            scan_frame_done_OutHigh <= 1'b0;
        end else begin
            state                   <= stateNext;
            rowIdx                  <= rowIdxNext;
            shadow                  <= shadowNext;
            scan_row_OutBUS         <= rowOutNext;
            scan_col_OutBUS         <= colOutNext;
            scan_frame_done_OutHigh <= frameDoneNext;
        end
    end

    // Outputs are decoded from the next state so the registered pins line up with the state.
    always_comb begin
        stateNext      = state;
        rowIdxNext     = rowIdx;
        shadowNext     = shadow;
        rowOutNext     = '0;
        colOutNext     = '0;
        frameDoneNext  = 1'b0;
        timerLoad      = 1'b0;
        timerLoadValue = ROW_RELOAD;

        if (!scan_enable_InHigh) begin
            stateNext  = IDLE;
            rowIdxNext = '0;
        end else begin
            case (state)
                IDLE: begin
                    stateNext = LOAD;
                end
                LOAD: begin
                    shadowNext     = rowSlice;
                    timerLoad      = 1'b1;
                    timerLoadValue = ROW_RELOAD;
                    rowOutNext     = rowOneHot;
                    colOutNext     = rowSlice;
                    stateNext      = DISPLAY;
                end
                DISPLAY: begin
                    if (timerZero) begin
                        timerLoad      = 1'b1;
                        timerLoadValue = BLANK_RELOAD;
                        stateNext      = BLANK;
                    end else begin
                        rowOutNext = rowOneHot;
                        colOutNext = shadow;
                    end
                end
                BLANK: begin
                    if (timerZero) begin
                        rowIdxNext    = (rowIdx == LAST_ROW) ? '0 : rowIdx + 1'b1;
                        frameDoneNext = (rowIdx == LAST_ROW);
                        stateNext     = LOAD;
                    end
                end
                default: begin
                    stateNext  = IDLE;
                    rowIdxNext = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sc_matrix_scan.sv
// tb/tb_sc_matrix_scan.sv - self-checking bench for sc_matrix_scan (8-row and 5-row edge instances)
module tb_sc_matrix_scan;

    logic        clk = 1'b0;
    logic        rst;
    logic        enA, enB;
    logic [63:0] dataA;
    logic [39:0] dataB;
    logic [7:0]  rowA, colA, colB;
    logic [4:0]  rowB;
    logic        fdA, fdB;

    always #10 clk = ~clk;

    sc_matrix_scan #(.DATAWIDTH(8), .ROWS(8), .ROW_CYCLES(4), .BLANK_CYCLES(2)) u_dutA (
        .SC_RegGENERAL_CLOCK_50     (clk),
        .SC_RegGENERAL_RESET_InHigh (rst),
        .scan_enable_InHigh         (enA),
        .scan_data_InBUS            (dataA),
        .scan_row_OutBUS            (rowA),
        .scan_col_OutBUS            (colA),
        .scan_frame_done_OutHigh    (fdA)
    );

    sc_matrix_scan #(.DATAWIDTH(8), .ROWS(5), .ROW_CYCLES(1), .BLANK_CYCLES(1)) u_dutB (
        .SC_RegGENERAL_CLOCK_50     (clk),
        .SC_RegGENERAL_RESET_InHigh (rst),
        .scan_enable_InHigh         (enB),
        .scan_data_InBUS            (dataB),
        .scan_row_OutBUS            (rowB),
        .scan_col_OutBUS            (colB),
        .scan_frame_done_OutHigh    (fdB)
    );

    // Reference: time since scan start, split into fixed row periods of LOAD + lit + blank.
    typedef struct {
        bit         running;
        int         t;
        logic [7:0] snap;
    } mdl_t;

    typedef struct {
        logic       en;
        logic [7:0] expRow;
        logic [7:0] expCol;
        logic       expFd;
    } vec_t;

    mdl_t mA, mB;
    int   nCmp = 0, nFail = 0, cyc = 0;
    int   lastFdA = -1, fdGapA = 0, fdCntA = 0;
    int   lastFdB = -1, fdGapB = 0;
    logic [4:0] lastLitB = '0;

    function automatic void mstep(inout mdl_t m, input int rows, input int rc, input int bc,
                                  input logic rstv, input logic en, input logic [63:0] d,
                                  output logic [7:0] er, output logic [7:0] ec, output logic ef);
        int p, o, r;
        p  = 1 + rc + bc;
        er = '0;
        ec = '0;
        ef = 1'b0;
        if (rstv || !en) begin
            m.running = 0;
            m.t = 0;
            return;
        end
        if (!m.running) begin
            m.running = 1;
            m.t = 0;
            return;
        end
        if (m.t % p == 0) m.snap = d[((m.t / p) % rows) * 8 +: 8];
        m.t++;
        o = m.t % p;
        r = (m.t / p) % rows;
        if (o == 0) ef = (r == 0);
        else if (o <= rc) begin
            er = 8'(1 << r);
            ec = m.snap;
        end
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        nCmp++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        logic [7:0] er, ec;
        logic ef;
        @(posedge clk);
        mstep(mA, 8, 4, 2, rst, enA, dataA, er, ec, ef);
        #1;
        cyc++;
        check("modelRowA", rowA, er);
        check("modelColA", colA, ec);
        check("modelFdA", {7'b0, fdA}, {7'b0, ef});
        mstep(mB, 5, 1, 1, rst, enB, {24'b0, dataB}, er, ec, ef);
        check("modelRowB", {3'b0, rowB}, er);
        check("modelColB", colB, ec);
        check("modelFdB", {7'b0, fdB}, {7'b0, ef});
        if (fdA) begin
            if (lastFdA >= 0) fdGapA = cyc - lastFdA;
            lastFdA = cyc;
            fdCntA++;
        end
        if (fdB) begin
            if (lastFdB >= 0) fdGapB = cyc - lastFdB;
            lastFdB = cyc;
        end
        if (rowB != '0) begin
            if (lastLitB == 5'h10) check("wrapB", {3'b0, rowB}, 8'h01);
            lastLitB = rowB;
        end
    endtask

    task automatic waitRowA(input logic [7:0] target, input string name);
        int n = 0;
        while (rowA !== target && n < 300) begin
            step();
            n++;
        end
        check(name, rowA, target);
    endtask

    vec_t vec[10];

    initial begin
        vec[0] = '{1'b0, 8'h00, 8'h00, 1'b0};
        vec[1] = '{1'b1, 8'h00, 8'h00, 1'b0};
        vec[2] = '{1'b1, 8'h01, 8'hA5, 1'b0};
        vec[3] = '{1'b1, 8'h01, 8'hA5, 1'b0};
        vec[4] = '{1'b1, 8'h01, 8'hA5, 1'b0};
        vec[5] = '{1'b1, 8'h01, 8'hA5, 1'b0};
        vec[6] = '{1'b1, 8'h00, 8'h00, 1'b0};
        vec[7] = '{1'b1, 8'h00, 8'h00, 1'b0};
        vec[8] = '{1'b1, 8'h00, 8'h00, 1'b0};
        vec[9] = '{1'b1, 8'h02, 8'h00, 1'b0};

        mA = '{0, 0, 8'h00};
        mB = '{0, 0, 8'h00};
        rst   = 1'b1;
        enA   = 1'b0;
        enB   = 1'b1;
        dataA = 64'h0000_0000_0000_00A5;
        dataB = 40'h10_3C_C3_5A_81;
        step();
        step();
        check("resetRowA", rowA, 8'h00);
        check("resetColA", colA, 8'h00);
        check("resetFdA", {7'b0, fdA}, 8'h00);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            enA = vec[i].en;
            step();
            check($sformatf("vecRow%0d", i), rowA, vec[i].expRow);
            check($sformatf("vecCol%0d", i), colA, vec[i].expCol);
            check($sformatf("vecFd%0d", i), {7'b0, fdA}, {7'b0, vec[i].expFd});
        end

        // Walking-one image over two full frames from a fresh start.
        for (int r = 0; r < 8; r++) dataA[r*8 +: 8] = 8'(1 << r);
        enA = 1'b0;
        step();
        enA = 1'b1;
        lastFdA = -1;
        fdGapA  = 0;
        fdCntA  = 0;
        for (int i = 0; i < 113; i++) begin
            step();
            if (rowA != 8'h00) check("walkCol", colA, rowA);
        end
        check("frameCountA", 8'(fdCntA), 8'd2);
        check("frameGapA", 8'(fdGapA), 8'd56);
        check("frameGapB", 8'(fdGapB), 8'd15);

        // Row 3 changes while lit: the snapshot must hold until the row ends.
        dataA[24 +: 8] = 8'hFF;
        waitRowA(8'h04, "waitRow2");
        waitRowA(8'h08, "waitRow3");
        check("tearColStart", colA, 8'hFF);
        dataA[24 +: 8] = 8'h00;
        for (int i = 0; i < 3; i++) begin
            step();
            check("tearColHold", colA, 8'hFF);
        end
        step();
        waitRowA(8'h08, "waitRow3Next");
        check("tearColNext", colA, 8'h00);

        // Disable mid-row, then resume from row 0.
        waitRowA(8'h20, "waitRow5");
        enA = 1'b0;
        step();
        check("disRow", rowA, 8'h00);
        check("disCol", colA, 8'h00);
        check("disFd", {7'b0, fdA}, 8'h00);
        enA = 1'b1;
        step();
        step();
        check("resumeRow", rowA, 8'h01);

        // Asynchronous reset between clock edges.
        waitRowA(8'h04, "waitRowAsync");
        #5;
        rst = 1'b1;
        #1;
        check("asyncRowA", rowA, 8'h00);
        check("asyncColA", colA, 8'h00);
        check("asyncRowB", {3'b0, rowB}, 8'h00);
        step();
        rst = 1'b0;
        step();
        step();
        check("postResetRow", rowA, 8'h01);

        // Random data and enable churn against the reference model.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(7) == 0) dataA[$urandom_range(7)*8 +: 8] = 8'($urandom);
            if ($urandom_range(7) == 0) dataB[$urandom_range(4)*8 +: 8] = 8'($urandom);
            if ($urandom_range(39) == 0) enA = ($urandom_range(5) != 0);
            if ($urandom_range(59) == 0) enB = ($urandom_range(5) != 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule
